stack_burst_seq: RTL
====================

# stack_burst_seq

Burst sequencer that sits directly upstream of the 32-bit hardware stack in the EX stage. It turns a single multi-register PUSH or POP instruction into a train of one-word push or pop strobes. It reads push data from the register file and writes popped words back to the register file. It keeps a shadow depth count so overflow and underflow are reported instead of silently dropped, and it stalls the pipeline while a burst is in flight.

## Interface
- DEPTH, 1024, stack capacity in words
- DW, 32, data width
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_push  in  1  one-cycle request: push burst
- req_pop  in  1  one-cycle request: pop burst
- req_first  in  4  first register index of burst
- req_cnt  in  4  burst length minus one (1..16 words)
- busy  out  1  pipeline stall; high while a burst is in flight
- done  out  1  one-cycle pulse on the last cycle of a burst
- rf_raddr  out  4  register file read index (combinational read)
- rf_rdata  in  DW  register file read data
- push  out  1  stack push strobe, one word per cycle
- pop  out  1  stack pop strobe, one word per cycle
- wdata  out  DW  stack write data (= rf_rdata while push=1)
- stk_rdata  in  DW  stack's flopped read result; valid the cycle after a pop strobe
- rf_we  out  1  register file write enable
- rf_waddr  out  4  register file write index
- rf_wdata  out  DW  register file write data (= stk_rdata)
- depth  out  11  shadow word count, 0..DEPTH
- ovf_err  out  1  one-cycle pulse: push burst rejected
- unf_err  out  1  one-cycle pulse: pop burst rejected

## Operation
- Burst length n = req_cnt+1.
- The FSM has four states: IDLE, PUSH, POP, DRAIN.
- IDLE behaviour:
  - Requests are sampled only in IDLE. Requests while busy=1 are ignored.
  - If req_push and req_pop are both high, req_push wins.
- Acceptance checks:
  - A push is rejected if depth+n > DEPTH. A pop is rejected if depth < n.
  - On rejection: pulse ovf_err or unf_err the next cycle, stay in IDLE, and issue no strobes.
  - A rejected request does not raise busy or done.
- Accepted push: go to PUSH, with the index register idx=req_first and the remaining count rem=n.
  - In PUSH, each cycle: push=1, rf_raddr=idx, wdata=rf_rdata, depth+=1, idx+=1 (mod 16), rem-=1.
  - When rem reaches 1, that cycle pulses done and the next state is IDLE.
- Accepted pop: go to POP, with idx=req_first+req_cnt (mod 16).
  - Pops run highest index first, so a matching push/pop pair restores the registers.
  - In POP, each cycle: pop=1, depth-=1, idx-=1 (mod 16). The index of each strobe is delayed one cycle to rf_waddr.
  - After the last pop strobe, go to DRAIN. DRAIN performs the final write-back, pulses done, then returns to IDLE.
- Write-back: rf_we=1 exactly in the cycle after each pop strobe, with rf_wdata=stk_rdata.
- push and pop are never high in the same cycle.
- Outputs in IDLE: push=pop=rf_we=0, wdata=0, rf_raddr=0.
- depth arithmetic is 11-bit unsigned. It never exceeds DEPTH and never goes below 0, because rejection happens before any strobe.
- Reset mid-burst: on the next edge go to IDLE, set depth=0 and drive all strobes to 0; the partial burst is abandoned. The stack must be reset by the same system reset so that depth stays consistent.

## Timing
- Reset values: busy=0, done=0, push=0, pop=0, rf_we=0, wdata=0, rf_raddr=0, rf_waddr=0, rf_wdata=0, depth=0, ovf_err=0, unf_err=0.
- Cycle numbering: request in cycle t; first strobe in cycle t+1; busy=1 from t+1.
- Push burst of n: strobes in t+1..t+n; done and the last busy cycle are at t+n.
- Pop burst of n: strobes in t+1..t+n; write-backs in t+2..t+n+1 (DRAIN at t+n+1); done and the last busy cycle are at t+n+1.
- Back-to-back operation: a new request may be presented in the cycle after done. That request is sampled in IDLE and gives zero gap between bursts.
- Error pulses occur at t+1.
- depth reflects all strobes issued up to and including the previous cycle.

## Test plan
- Push burst: reset; push req_first=2, req_cnt=3 with R2..R5 = 0xA0..0xA3 -> push in 4 consecutive cycles, rf_raddr 2,3,4,5, wdata 0xA0..0xA3, depth=4, busy for 4 cycles, done at cycle 4.
- Pop round-trip: after the push above, clear R2..R5, then pop req_first=2, req_cnt=3 -> rf_waddr 5,4,3,2 with data 0xA3..0xA0, each one cycle after its strobe, depth=0, done at t+5.
- Index wrap: push req_first=14, req_cnt=3 -> rf_raddr 14,15,0,1.
- Overflow: fill to depth=1020, then push req_cnt=4 (5 words) -> ovf_err pulse, no push strobe, depth stays 1020; a following push of 4 words succeeds and gives depth=1024.
- Underflow and priority:
  - depth=2, pop req_cnt=2 -> unf_err pulse, no pop strobe.
  - req_push and req_pop high together -> a push burst runs.
  - A request raised while busy is ignored.
- Reset mid-burst: assert rst during the 3rd cycle of a 16-word push -> next cycle busy=0, push=0, depth=0, state IDLE; a new 1-word push then works normally.

Source files
------------

// File: rtl/stack_burst_seq.sv
// stack_burst_seq: turns one multi-register PUSH/POP instruction into a train
// of single-word stack strobes, with register-file read/write-back, a shadow
// depth count for overflow/underflow rejection, and a pipeline stall.
module stack_burst_seq #(
    parameter int DEPTH = 1024,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_push,
    input  logic          req_pop,
    input  logic [3:0]    req_first,
    input  logic [3:0]    req_cnt,
    output logic          busy,
    output logic          done,
    output logic [3:0]    rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          push,
    output logic          pop,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] stk_rdata,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [10:0]   depth,
    output logic          ovf_err,
    output logic          unf_err
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [4:0]  rem;
    logic [4:0]  req_len;
    logic [11:0] push_sum;
    logic        push_ok;
    logic        pop_ok;

    // Acceptance checks: the 12-bit sum keeps depth+n from wrapping.
    always_comb begin
        req_len  = {1'b0, req_cnt} + 5'd1;
        push_sum = {1'b0, depth} + {7'd0, req_len};
        push_ok  = (push_sum <= 12'(DEPTH));
        pop_ok   = (depth >= {6'd0, req_len});
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: requests only matter in IDLE, push has priority over pop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_push) begin
                    if (push_ok) begin
                        state_next = PUSH;
                    end
                end else if (req_pop && pop_ok) begin
                    state_next = POP;
                end
            end
            PUSH: begin
                if (rem == 5'd1) begin
                    state_next = IDLE;
                end
            end
            POP: begin
                if (rem == 5'd1) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; DRAIN exists only to cover the last write-back.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        rf_raddr = 4'd0;
        wdata    = '0;
        case (state)
            PUSH: begin
                busy     = 1'b1;
                push     = 1'b1;
                rf_raddr = idx;
                wdata    = rf_rdata;
                done     = (rem == 5'd1);
            end
            POP: begin
                busy = 1'b1;
                pop  = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Write-back data is only meaningful while rf_we is high; otherwise hold 0.
    always_comb begin
        rf_wdata = rf_we ? stk_rdata : '0;
    end

    // Burst datapath: index/remaining counters, shadow depth, error pulses and
    // the one-cycle delayed write-back strobe that lines up with stk_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 4'd0;
            rem      <= 5'd0;
            depth    <= 11'd0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= 4'd0;
        end else begin
            ovf_err <= (state == IDLE) && req_push && !push_ok;
            unf_err <= (state == IDLE) && !req_push && req_pop && !pop_ok;
            rf_we   <= (state == POP);
            if (state == POP) begin
                rf_waddr <= idx;
            end
            case (state)
                IDLE: begin
                    if (req_push) begin
                        idx <= req_first;
                        rem <= req_len;
                    end else if (req_pop) begin
                        idx <= req_first + req_cnt;
                        rem <= req_len;
                    end
                end
                PUSH: begin
                    idx   <= idx + 4'd1;
                    rem   <= rem - 5'd1;
                    depth <= depth + 11'd1;
                end
                POP: begin
                    idx   <= idx - 4'd1;
                    rem   <= rem - 5'd1;
                    depth <= depth - 11'd1;
                end
                default: begin
                    rem <= rem;
                end
            endcase
        end
    end

endmodule
